// File: rtl/fifo_unloader.sv
// Read-side FIFO controller: pops 64-bit words and serializes them into OUT_WIDTH beats on a valid/ready link.
// Optional macro FIFO_UNLOADER_MSB_FIRST_EN sends the most-significant slice first (default: LSB first).
module fifo_unloader #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_front,
  input  logic                  fifo_empty,
  output logic                  fifo_remove,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [DATA_WIDTH-1:0] hold_r;
  logic [0:0]            hold_valid_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic [CNT_W-1:0]      beat_idx_s;
  logic                  accept_s;
  logic                  last_s;
  logic                  remove_s;
  logic [OUT_WIDTH-1:0]  beat_arr_s [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    assign beat_arr_s[g] = hold_r[g*OUT_WIDTH +: OUT_WIDTH];
  end

  // Handshake terms; a pop happens when idle or when the final beat leaves.
  always_comb begin
    accept_s = (hold_valid_r == ST_SEND) && out_ready;
    last_s   = (hold_valid_r == ST_SEND) && (beat_cnt_r == LAST_BEAT);
    remove_s = reset && !fifo_empty && ((hold_valid_r == ST_IDLE) || (accept_s && last_s));
  end

  // Map the beat counter onto a slice index according to the configured order.
  always_comb begin
`ifdef FIFO_UNLOADER_MSB_FIRST_EN
    beat_idx_s = LAST_BEAT - beat_cnt_r;
`else
    beat_idx_s = beat_cnt_r;
`endif
  end

  // Holding register, beat counter and IDLE/SEND state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r       <= {DATA_WIDTH{1'b0}};
      hold_valid_r <= ST_IDLE;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (remove_s) begin
      hold_r       <= fifo_front;
      hold_valid_r <= ST_SEND;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s && !last_s) begin
      beat_cnt_r   <= beat_cnt_r + CNT_W'(1);
    end else if (accept_s && last_s) begin
      hold_valid_r <= ST_IDLE;
    end else begin
      hold_r       <= hold_r;
      hold_valid_r <= hold_valid_r;
      beat_cnt_r   <= beat_cnt_r;
    end
  end

  assign fifo_remove = remove_s;
  assign out_data    = beat_arr_s[beat_idx_s];
  assign out_valid   = (hold_valid_r == ST_SEND);
  assign out_last    = last_s;
  assign busy        = (hold_valid_r == ST_SEND);

endmodule
